w0rm_sync_sink: RTL and testbench
=================================

W0RM_SYNC_SINK -- requirements
Module: w0rm_sync_sink

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of the input data word.
REQ-002 SHALL have parameter WORD_COUNT, default 16, number of words in one checked stream (0 legal).
REQ-003 SHALL have parameter START_VALUE, default 0, first expected data word.
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  single-cycle request to begin or restart a check run.
REQ-007 SHALL have ports input_valid input 1, input_ready output 1, input_data input DATA_WIDTH: the consuming end of the W0RM valid/ready stream.
REQ-008 SHALL have port done  output  1  run complete.
REQ-009 SHALL have port error  output  1  sticky: at least one mismatch in current run.
REQ-010 SHALL have port error_count  output  16  mismatch count, saturating at 16'hFFFF.
REQ-011 SHALL have port word_count  output  16  words accepted in current run.

Function
REQ-012 SHALL implement states IDLE, RUN, DONE; IDLE after reset.
REQ-013 IDLE: input_ready=0; start -> RUN next cycle, expected=START_VALUE, error/error_count/word_count cleared.
REQ-014 Transfer SHALL occur only on a cycle with input_valid=1 and input_ready=1 in RUN; no other cycle alters counters.
REQ-015 input_ready SHALL be driven from a register; no combinational path from input_valid or input_data.
REQ-016 On transfer: input_data != expected -> error_count+1 (saturating) and error=1, both visible the next cycle.
REQ-017 expected SHALL increment by 1 on every transfer, match or not, wrapping modulo 2^DATA_WIDTH (8'hFF -> 8'h00).
REQ-018 Transfer of word number WORD_COUNT SHALL move to DONE next cycle; input_ready=0 that same next cycle; done=1.
REQ-019 WORD_COUNT=0: start in IDLE SHALL go directly to DONE with zero counts.
REQ-020 DONE: done=1, input_ready=0, counters held; start -> RUN with all run state cleared and done=0 next cycle.
REQ-021 start asserted in RUN SHALL be ignored.
REQ-022 input_valid deassertion mid-run (bubbles) SHALL not affect counts or expected value.

Reset
REQ-023 Reset assertion SHALL immediately force IDLE, input_ready=0, done=0, error=0, error_count=0, word_count=0, expected=START_VALUE, throttle LFSR=8'hA5, regardless of state.
REQ-024 Reset release SHALL be synchronized internally; first state change no earlier than second rising edge after release.

Configuration
REQ-025 Macro W0RM_SYNC_SINK_THROTTLE_EN defined: in RUN an 8-bit Galois LFSR (taps 8,6,5,4, seed 8'hA5) advances every cycle; input_ready=0 on cycles where LFSR[1:0]==2'b00, else 1.
REQ-026 Macro undefined: input_ready=1 on every RUN cycle; no LFSR logic present.

Structure
REQ-027 Shared package w0rm_sync_pkg SHALL hold the state enumeration, LFSR seed/tap constants, and counter width constant (16).
REQ-028 Throttle LFSR SHALL be sub-module w0rm_lfsr8 (clk, reset, enable, value); all else in one module.

Verification
REQ-029 WORD_COUNT=4, START_VALUE=8'h10, throttle off, stream 10,11,12,13 with valid held -> input_ready high 4 cycles, done=1, error=0, word_count=4.
REQ-030 Same, stream 10,11,FF,13 -> error=1 cycle after 3rd transfer, error_count=1, done=1 after 4th.
REQ-031 START_VALUE=8'hFE, WORD_COUNT=4, stream FE,FF,00,01 -> no error (wrap).
REQ-032 Throttle on, 16 words with valid held -> input_ready pattern equals LFSR model, all 16 accepted, error=0, no transfer on ready=0 cycles.
REQ-033 Reset asserted after 2 of 4 words -> outputs zero same cycle; start then stream 4 words from START_VALUE -> pass.
REQ-034 WORD_COUNT=0, start -> done=1 next cycle, word_count=0; start again in DONE -> done=0 then 1 again.

Source files
------------

// File: rtl/w0rm_sync_pkg.sv
// Shared types and constants for the W0RM sync sink: FSM states, counter width, throttle LFSR.
// Pure declarations; no latency or backpressure of its own.
package w0rm_sync_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int         CNT_W     = 16;
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    // Galois right-shift form of x^8 + x^6 + x^5 + x^4 + 1
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        lfsr_step = {1'b0, v[7:1]} ^ (v[0] ? LFSR_TAPS : 8'h00);
    endfunction

endpackage

// File: rtl/w0rm_lfsr8.sv
// 8-bit Galois LFSR used to throttle input_ready; advances one step per enabled cycle.
// Built only with W0RM_SYNC_SINK_THROTTLE_EN; no backpressure, value is registered.
`ifdef W0RM_SYNC_SINK_THROTTLE_EN
module w0rm_lfsr8
    import w0rm_sync_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    output logic [7:0] value
);

    logic [7:0] r_lfsr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lfsr <= LFSR_SEED;
        end else if (enable) begin
            r_lfsr <= lfsr_step(r_lfsr);
        end
    end

    assign value = r_lfsr;

endmodule
`endif

// File: rtl/w0rm_sync_sink.sv
// Checks a W0RM valid/ready stream against an incrementing pattern; mismatch stats visible one cycle after transfer.
// input_ready is a flop, never combinational from input_valid; define W0RM_SYNC_SINK_THROTTLE_EN for LFSR-throttled ready.
module w0rm_sync_sink
    import w0rm_sync_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int WORD_COUNT  = 16,
    parameter int START_VALUE = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  input_valid,
    output logic                  input_ready,
    input  logic [DATA_WIDTH-1:0] input_data,
    output logic                  done,
    output logic                  error,
    output logic [CNT_W-1:0]      error_count,
    output logic [CNT_W-1:0]      word_count
);

    localparam logic [DATA_WIDTH-1:0] START_V  = DATA_WIDTH'(START_VALUE);
    localparam logic [CNT_W-1:0]      LAST_IDX = CNT_W'(WORD_COUNT - 1);
    localparam bit                    ZERO_RUN = (WORD_COUNT == 0);

    logic [1:0]            r_rst_sync;
    logic                  w_rst_n;
    state_t                r_state;
    state_t                w_next_state;
    logic                  r_ready;
    logic [DATA_WIDTH-1:0] r_expected;
    logic                  r_error;
    logic [CNT_W-1:0]      r_err_cnt;
    logic [CNT_W-1:0]      r_word_cnt;
    logic                  w_xfer;
    logic                  w_last;
    logic                  w_clear;
    logic                  w_slot_open;

    // Assert asynchronously, release only after two clean edges
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end
    assign w_rst_n = r_rst_sync[1];

    assign w_xfer  = (r_state == ST_RUN) && r_ready && input_valid;
    assign w_last  = (r_word_cnt == LAST_IDX);
    assign w_clear = start && (r_state != ST_RUN);

`ifdef W0RM_SYNC_SINK_THROTTLE_EN
    logic       w_lfsr_en;
    logic [7:0] w_lfsr_value;
    logic [7:0] w_lfsr_next;

    assign w_lfsr_en = (r_state == ST_RUN);

    w0rm_lfsr8 u_lfsr (
        .clk    (clk),
        .reset  (w_rst_n),
        .enable (w_lfsr_en),
        .value  (w_lfsr_value)
    );

    // Ready is registered, so look at the LFSR value the next cycle will see
    assign w_lfsr_next = w_lfsr_en ? lfsr_step(w_lfsr_value) : w_lfsr_value;
    assign w_slot_open = (w_lfsr_next[1:0] != 2'b00);
`else
    assign w_slot_open = 1'b1;
`endif

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (start) w_next_state = ZERO_RUN ? ST_DONE : ST_RUN;
            // An empty run restarted from DONE still spends one cycle in RUN so done visibly drops
            ST_RUN:  if (ZERO_RUN || (w_xfer && w_last)) w_next_state = ST_DONE;
            ST_DONE: if (start) w_next_state = ST_RUN;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_ready <= 1'b0;
        end else begin
            r_ready <= (w_next_state == ST_RUN) && !ZERO_RUN && w_slot_open;
        end
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_expected <= START_V;
            r_error    <= 1'b0;
            r_err_cnt  <= '0;
            r_word_cnt <= '0;
        end else if (w_clear) begin
            r_expected <= START_V;
            r_error    <= 1'b0;
            r_err_cnt  <= '0;
            r_word_cnt <= '0;
        end else if (w_xfer) begin
            r_expected <= r_expected + 1'b1;
            r_word_cnt <= r_word_cnt + 1'b1;
            if (input_data != r_expected) begin
                r_error <= 1'b1;
                if (r_err_cnt != '1) begin
                    r_err_cnt <= r_err_cnt + 1'b1;
                end
            end
        end
    end

    assign input_ready = r_ready;
    assign done        = (r_state == ST_DONE);
    assign error       = r_error;
    assign error_count = r_err_cnt;
    assign word_count  = r_word_cnt;

endmodule

// File: tb/tb_w0rm_sync_sink.sv
// Directed bench for w0rm_sync_sink: four parameterisations share clock, reset and stream inputs.
// Expected counts and flags come from hand-written vectors and a small pattern/LFSR model.
module tb_w0rm_sync_sink;

`ifdef W0RM_SYNC_SINK_THROTTLE_EN
    localparam bit THR = 1'b1;
`else
    localparam bit THR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        in_vld;
    logic [7:0]  in_dat;
    logic        st  [4];
    logic        rdy [4];
    logic        dn  [4];
    logic        er  [4];
    logic [15:0] ec  [4];
    logic [15:0] wc  [4];

    int          checks   = 0;
    int          failures = 0;
    logic [7:0]  stim [16];
    logic [7:0]  exp_val;
    int          mism;
    logic [7:0]  m [4];
    int          rcnt;

    always #5 clk = ~clk;

    w0rm_sync_sink #(.DATA_WIDTH(8), .WORD_COUNT(4), .START_VALUE(8'h10)) dut_a (
        .clk(clk), .reset(reset), .start(st[0]), .input_valid(in_vld), .input_ready(rdy[0]),
        .input_data(in_dat), .done(dn[0]), .error(er[0]), .error_count(ec[0]), .word_count(wc[0]));

    w0rm_sync_sink #(.DATA_WIDTH(8), .WORD_COUNT(4), .START_VALUE(8'hFE)) dut_b (
        .clk(clk), .reset(reset), .start(st[1]), .input_valid(in_vld), .input_ready(rdy[1]),
        .input_data(in_dat), .done(dn[1]), .error(er[1]), .error_count(ec[1]), .word_count(wc[1]));

    w0rm_sync_sink #(.DATA_WIDTH(8), .WORD_COUNT(0), .START_VALUE(0)) dut_c (
        .clk(clk), .reset(reset), .start(st[2]), .input_valid(in_vld), .input_ready(rdy[2]),
        .input_data(in_dat), .done(dn[2]), .error(er[2]), .error_count(ec[2]), .word_count(wc[2]));

    w0rm_sync_sink #(.DATA_WIDTH(8), .WORD_COUNT(16), .START_VALUE(0)) dut_d (
        .clk(clk), .reset(reset), .start(st[3]), .input_valid(in_vld), .input_ready(rdy[3]),
        .input_data(in_dat), .done(dn[3]), .error(er[3]), .error_count(ec[3]), .word_count(wc[3]));

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Galois right shift, taps 8,6,5,4
    function automatic logic [7:0] lfsr_model(input logic [7:0] v);
        logic [7:0] s;
        s = v >> 1;
        if (v[0]) s = s ^ 8'b1011_1000;
        return s;
    endfunction

    task automatic pulse_start(input int s);
        st[s] = 1'b1;
        tick();
        st[s] = 1'b0;
    endtask

    // Hold valid until words [from,to) are accepted; every loop pass is one RUN cycle of DUT s
    task automatic stream(input int s, input int from, input int to, output int rc);
        int   idx;
        int   budget;
        logic exp_rdy;
        idx    = from;
        budget = 0;
        rc     = 0;
        in_vld = 1'b1;
        in_dat = stim[idx];
        while (idx < to && budget < 200) begin
            exp_rdy = THR ? (m[s][1:0] != 2'b00) : 1'b1;
            chk_eq("ready_pattern", rdy[s], exp_rdy);
            m[s] = lfsr_model(m[s]);
            if (rdy[s]) begin
                rc++;
                if (stim[idx] != exp_val) mism++;
                exp_val = exp_val + 8'd1;
                idx++;
            end
            tick();
            chk_eq("word_count", wc[s], idx);
            chk_eq("error_flag", er[s], mism > 0);
            chk_eq("error_count", ec[s], mism);
            if (idx < to) in_dat = stim[idx];
            budget++;
        end
        chk_eq("stream_budget", budget < 200, 1'b1);
        in_vld = 1'b0;
    endtask

    task automatic end_chk(input int s, input string t, input logic d, input logic e,
                           input logic [15:0] c, input logic [15:0] w);
        chk_eq({t, "_done"},  dn[s],  d);
        chk_eq({t, "_ready"}, rdy[s], 1'b0);
        chk_eq({t, "_err"},   er[s],  e);
        chk_eq({t, "_ecnt"},  ec[s],  c);
        chk_eq({t, "_wcnt"},  wc[s],  w);
    endtask

    task automatic load4(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                         input logic [7:0] d, input logic [7:0] start_v);
        stim[0] = a; stim[1] = b; stim[2] = c; stim[3] = d;
        exp_val = start_v;
        mism    = 0;
    endtask

    initial begin
        reset  = 1'b1;
        in_vld = 1'b0;
        in_dat = 8'h00;
        for (int i = 0; i < 4; i++) begin
            st[i] = 1'b0;
            m[i]  = 8'hA5;
        end

        #2 reset = 1'b0;
        #1;
        end_chk(0, "rst_init", 1'b0, 1'b0, 16'd0, 16'd0);
        tick();
        tick();

        // Start held across the two synchroniser edges must be ignored
        reset = 1'b1;
        st[2] = 1'b1;
        tick();
        chk_eq("sync_edge1_done", dn[2], 1'b0);
        tick();
        chk_eq("sync_edge2_done", dn[2], 1'b0);
        st[2] = 1'b0;
        tick();

        // Empty run: straight to DONE, restart drops done for one cycle
        pulse_start(2);
        end_chk(2, "zero_run", 1'b1, 1'b0, 16'd0, 16'd0);
        tick();
        chk_eq("zero_hold_done", dn[2], 1'b1);
        pulse_start(2);
        chk_eq("zero_restart_done", dn[2], 1'b0);
        chk_eq("zero_restart_ready", rdy[2], 1'b0);
        tick();
        chk_eq("zero_redone", dn[2], 1'b1);

        // Clean run 10..13
        load4(8'h10, 8'h11, 8'h12, 8'h13, 8'h10);
        pulse_start(0);
        stream(0, 0, 4, rcnt);
        chk_eq("clean_ready_cycles", rcnt, 4);
        end_chk(0, "clean", 1'b1, 1'b0, 16'd0, 16'd4);

        // Restart from DONE, one bad word, start ignored mid-run with a bubble
        load4(8'h10, 8'h11, 8'hFF, 8'h13, 8'h10);
        pulse_start(0);
        chk_eq("restart_done", dn[0], 1'b0);
        chk_eq("restart_wcnt", wc[0], 16'd0);
        stream(0, 0, 2, rcnt);
        st[0] = 1'b1;
        m[0]  = lfsr_model(m[0]);
        tick();
        st[0] = 1'b0;
        chk_eq("ignored_start_wcnt", wc[0], 16'd2);
        chk_eq("ignored_start_done", dn[0], 1'b0);
        stream(0, 2, 4, rcnt);
        end_chk(0, "bad_word", 1'b1, 1'b1, 16'd1, 16'd4);

        // Expected value wraps FF -> 00
        load4(8'hFE, 8'hFF, 8'h00, 8'h01, 8'hFE);
        pulse_start(1);
        stream(1, 0, 4, rcnt);
        end_chk(1, "wrap", 1'b1, 1'b0, 16'd0, 16'd4);

        // Sixteen words, ready pattern checked cycle by cycle
        for (int i = 0; i < 16; i++) stim[i] = 8'(i);
        exp_val = 8'h00;
        mism    = 0;
        pulse_start(3);
        stream(3, 0, 16, rcnt);
        chk_eq("long_ready_cycles", rcnt, 16);
        end_chk(3, "long", 1'b1, 1'b0, 16'd0, 16'd16);

        // Reset in the middle of a run with an error already latched
        load4(8'h10, 8'hEE, 8'h12, 8'h13, 8'h10);
        pulse_start(0);
        stream(0, 0, 2, rcnt);
        reset = 1'b0;
        #1;
        end_chk(0, "mid_reset", 1'b0, 1'b0, 16'd0, 16'd0);
        tick();
        tick();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) m[i] = 8'hA5;
        tick();
        tick();
        tick();
        load4(8'h10, 8'h11, 8'h12, 8'h13, 8'h10);
        pulse_start(0);
        stream(0, 0, 4, rcnt);
        end_chk(0, "after_reset", 1'b1, 1'b0, 16'd0, 16'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
